// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The IF_ALIGN_CHECK_EN build option uses pc_fault() to reject out-of-window or misaligned PCs.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } if_state_t;

    localparam logic [31:0] IF_BASE_ADDR = 32'h0040_0000;
    localparam logic [31:0] IF_NOP       = 32'h0000_0000;

    // True when pc is misaligned or falls outside [base, base + 4*2^aw).
    function automatic logic pc_fault(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int unsigned aw);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'd1 << (aw + 2));
        return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/if_out_buf.sv
// Single-entry valid/ready holding register between fetch and decode.
// Flush wins over load and consume; a load in the same edge as a consume keeps the entry valid.
module if_out_buf
    import if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        load_fault,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            inst    <= '0;
            inst_pc <= BASE_ADDR;
            fault   <= 1'b0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end

            if (load && !flush) begin
                inst    <= load_inst;
                inst_pc <= load_pc;
                fault   <= load_fault;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues imem requests for the current PC, buffers the word for decode,
// pulses pc_advance on delivery and drains in-flight requests on redirect. Option: IF_ALIGN_CHECK_EN.
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IF_BASE_ADDR,
    parameter int          IMEM_AW   = 10
) (
    input  logic               if_clk,
    input  logic               rst_n,
    input  logic [31:0]        pc_addr_in,
    input  logic               redirect,
    output logic [31:0]        next_pc,
    output logic               pc_advance,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_fault
);

    if_state_t   state;
    if_state_t   state_nx;
    logic [31:0] req_pc;
    logic        can_accept;
    logic        fetch_fault;
    logic        issue;
    logic        buf_load;
    logic [31:0] ld_inst;
    logic [31:0] ld_pc;
    logic        ld_fault;

    assign can_accept = !inst_valid || inst_ready;
    assign next_pc    = req_pc + 32'd4;

`ifdef IF_ALIGN_CHECK_EN
    assign fetch_fault = pc_fault(pc_addr_in, BASE_ADDR, IMEM_AW);
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge if_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (can_accept && !redirect && !fetch_fault) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                // An ack closes the bus transaction whether or not a redirect discards it.
                if (imem_ack) begin
                    state_nx = IDLE;
                end else if (redirect) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue      = 1'b0;
        pc_advance = 1'b0;
        buf_load   = 1'b0;
        ld_inst    = imem_rdata;
        ld_pc      = req_pc;
        ld_fault   = 1'b0;
        case (state)
            IDLE: begin
                if (can_accept && !redirect) begin
                    if (fetch_fault) begin
                        // Faulting PC: deliver a flagged NOP without touching memory.
                        pc_advance = 1'b1;
                        buf_load   = 1'b1;
                        ld_inst    = IF_NOP;
                        ld_pc      = pc_addr_in;
                        ld_fault   = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            REQ: begin
                if (imem_ack && !redirect) begin
                    pc_advance = 1'b1;
                    buf_load   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus request stays high for exactly the REQ and DRAIN states.
    always_ff @(posedge if_clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            req_pc    <= BASE_ADDR;
        end else begin
            imem_req <= (state_nx != IDLE);
            if (issue) begin
                req_pc    <= pc_addr_in;
                imem_addr <= IMEM_AW'((pc_addr_in - BASE_ADDR) >> 2);
            end
        end
    end

    if_out_buf #(
        .BASE_ADDR (BASE_ADDR)
    ) u_out_buf (
        .clk        (if_clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .consume    (inst_ready),
        .flush      (redirect),
        .load_inst  (ld_inst),
        .load_pc    (ld_pc),
        .load_fault (ld_fault),
        .valid      (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fault      (inst_fault)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: bench-side PC register, memory responder and
// an expected-instruction queue filled on each ack and drained as decode consumes.
module tb_inst_fetch;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          AW   = 10;

    logic          if_clk;
    logic          rst_n;
    logic [31:0]   pc_addr_in;
    logic          redirect;
    logic [31:0]   next_pc;
    logic          pc_advance;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_fault;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t          sb[$];
    int            n_checks;
    int            n_errors;
    int            adv_cnt;
    int            mem_wait;
    int            wcnt;
    bit            mem_en;
    logic          discard;
    logic [31:0]   req_pc_exp;
    logic [31:0]   redir_tgt;
    logic [31:0]   last_pop_pc;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] hold_addr;
    int            n;

    inst_fetch #(
        .BASE_ADDR (BASE),
        .IMEM_AW   (AW)
    ) dut (
        .if_clk     (if_clk),
        .rst_n      (rst_n),
        .pc_addr_in (pc_addr_in),
        .redirect   (redirect),
        .next_pc    (next_pc),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault)
    );

    initial if_clk = 1'b0;
    always #5 if_clk = ~if_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h2008_0005 ^ (32'(a) << 12);
    endfunction

    function automatic logic bad_pc(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < BASE) || (pc >= BASE + 32'h0000_1000);
    endfunction

    // One clock cycle: check pre-edge outputs, update the model, advance, respond as memory.
    task automatic tick();
        logic        exp_adv;
        logic        prev_req;
        logic [31:0] prev_pc;
        logic [31:0] pc_nx;
        exp_t        e;
        #1;
        exp_adv = imem_req && imem_ack && !redirect && !discard;
`ifdef IF_ALIGN_CHECK_EN
        if (!imem_req && (!inst_valid || inst_ready) && !redirect && bad_pc(pc_addr_in))
            exp_adv = 1'b1;
`endif
        chk("pc_advance", 32'(pc_advance), 32'(exp_adv));
        if (pc_advance) adv_cnt++;
        if (exp_adv) chk("next_pc", next_pc, req_pc_exp + 32'd4);

        if (inst_valid && inst_ready && !redirect) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("inst", inst, e.inst);
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_fault", 32'(inst_fault), 32'(e.fault));
                last_pop_pc = inst_pc;
            end
        end
        if (redirect) begin
            sb.delete();
            if (imem_req && !imem_ack) discard = 1'b1;
        end
        if (imem_req && imem_ack && !redirect && !discard)
            sb.push_back('{inst: mem_word(exp_addr), pc: req_pc_exp, fault: 1'b0});
`ifdef IF_ALIGN_CHECK_EN
        if (!imem_req && (!inst_valid || inst_ready) && !redirect && bad_pc(pc_addr_in))
            sb.push_back('{inst: 32'h0, pc: pc_addr_in, fault: 1'b1});
`endif

        if (redirect)     pc_nx = redir_tgt;
        else if (exp_adv) pc_nx = req_pc_exp + 32'd4;
        else              pc_nx = pc_addr_in;
        prev_req = imem_req;
        prev_pc  = pc_addr_in;

        @(posedge if_clk);
        #1;
        pc_addr_in = pc_nx;
        redirect   = 1'b0;
        if (!prev_req && imem_req) begin
            req_pc_exp = prev_pc;
            exp_addr   = AW'((prev_pc - BASE) >> 2);
            chk("imem_addr_issue", 32'(imem_addr), 32'(exp_addr));
        end else if (prev_req && imem_req) begin
            chk("imem_addr_hold", 32'(imem_addr), 32'(exp_addr));
        end
        if (!imem_req) discard = 1'b0;

        if (imem_req && mem_en) begin
            if (wcnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        while (!imem_req && k < budget) begin
            tick();
            k++;
        end
        chk("wait_req", 32'(imem_req), 32'd1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; adv_cnt = 0; wcnt = 0;
        rst_n = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; pc_addr_in = BASE;
        mem_en = 1'b1; mem_wait = 2; discard = 1'b0;
        req_pc_exp = BASE; redir_tgt = BASE; exp_addr = '0; last_pop_pc = 32'h0;

        repeat (2) @(posedge if_clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, BASE);
        chk("rst_inst_fault", 32'(inst_fault), 32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        chk("rst_next_pc", next_pc, BASE + 32'd4);

        // Basic fetch with two wait cycles
        rst_n = 1'b1;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("basic_valid", 32'(inst_valid), 32'd1);
        chk("basic_inst", inst, 32'h2008_0005);
        chk("basic_inst_pc", inst_pc, BASE);
        chk("basic_adv_cnt", 32'(adv_cnt), 32'd1);

        // Backpressure
        repeat (10) begin
            tick();
            chk("bp_no_req", 32'(imem_req), 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        chk("bp_req", 32'(imem_req), 32'd1);
        chk("bp_addr", 32'(imem_addr), 32'd1);

        // Streaming with random wait states and decode stalls
        for (int i = 0; i < 40; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            mem_wait   = $urandom_range(0, 2);
            tick();
        end
        inst_ready = 1'b1;
        mem_wait   = 0;

        // Redirect before ack
        mem_en = 1'b0;
        tick();
        wait_req(20);
        redirect = 1'b1; redir_tgt = 32'h0040_0100;
        tick();
        chk("rdb_valid", 32'(inst_valid), 32'd0);
        chk("rdb_req_held", 32'(imem_req), 32'd1);
        hold_addr = imem_addr;
        tick();
        tick();
        chk("drain_addr", 32'(imem_addr), 32'(hold_addr));
        redirect = 1'b1; redir_tgt = 32'h0040_0100;
        tick();
        mem_en = 1'b1;
        tick();
        tick();
        chk("drain_done", 32'(imem_req), 32'd0);
        chk("drain_valid", 32'(inst_valid), 32'd0);
        wait_req(5);
        chk("redir_addr", 32'(imem_addr), 32'h40);

        // Redirect with ack in the same cycle
        redirect = 1'b1; redir_tgt = 32'h0040_0200;
        tick();
        chk("rwa_idle", 32'(imem_req), 32'd0);
        chk("rwa_valid", 32'(inst_valid), 32'd0);
        wait_req(5);
        chk("rwa_addr", 32'(imem_addr), 32'h80);

        // Misaligned PC
        tick();
        redirect = 1'b1; redir_tgt = 32'h0040_0002;
        tick();
`ifdef IF_ALIGN_CHECK_EN
        tick();
        chk("align_no_req", 32'(imem_req), 32'd0);
        chk("align_valid", 32'(inst_valid), 32'd1);
        chk("align_fault", 32'(inst_fault), 32'd1);
        chk("align_inst", inst, 32'h0);
        chk("align_pc", inst_pc, 32'h0040_0002);
`else
        wait_req(3);
        chk("align_addr", 32'(imem_addr), 32'd0);
`endif
        repeat (10) tick();

        // Reset in the middle of a request
        mem_en = 1'b0;
        tick();
        wait_req(20);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, BASE);
        chk("mid_rst_fault", 32'(inst_fault), 32'd0);
        chk("mid_rst_next_pc", next_pc, BASE + 32'd4);
        chk("mid_rst_adv", 32'(pc_advance), 32'd0);
        sb.delete();
        discard = 1'b0; wcnt = 0; pc_addr_in = BASE; req_pc_exp = BASE;
        mem_en = 1'b1; mem_wait = 1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge if_clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_first_req", 32'(imem_req), 32'd1);
        chk("rst_first_addr", 32'(imem_addr), 32'd0);
        repeat (4) tick();
        chk("rst_refetch_pc", last_pop_pc, BASE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
